mul_rpt_add: RTL and testbench
==============================

# mul_rpt_add

Sequential unsigned multiplier that computes a product by repeated addition. Operand B is the loop counter. A controller FSM steps a small datapath (A register, B down-counter, product accumulator) and consumes internal zero-detect flags on A and B to decide when to stop. It sits beside the 32-bit datapath as a multi-cycle arithmetic unit, started by a one-cycle request and reporting completion with a one-cycle `done` pulse.

## Interface
- `W`, 32, operand and product width in bits (W ≥ 2).

- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  reset; synchronous and active-high.
- `start`  input  1  request pulse, sampled only in IDLE.
- `a_in`  input  W  multiplicand, captured when `start` is accepted.
- `b_in`  input  W  multiplier (iteration count), captured when `start` is accepted.
- `product`  output  W  accumulator, modulo 2^W; registered.
- `busy`  output  1  high while a multiplication is in progress (CHECK or ADD state); registered.
- `done`  output  1  one-cycle completion pulse (DONE state); registered.
- `ovf`  output  1  sticky carry-out of any accumulate in the current operation; registered.

## Operation
- Internal registers:
  - `A_r` (W bits), `B_r` (W-bit down-counter), `P_r` (W bits, drives `product`).
  - `ovf_r`.
  - 2-bit state register.
- Zero flags: `eqz_a = (A_r == 0)` and `eqz_b = (B_r == 0)`. Both are full W-bit compares and are combinational from the registers.
- FSM states: IDLE, CHECK, ADD, DONE.
- IDLE:
  - `start=0`: stay in IDLE.
  - `start=1`: `A_r<=a_in`, `B_r<=b_in`, `P_r<=0`, `ovf_r<=0`, next state CHECK.
- CHECK:
  - `eqz_a` or `eqz_b`: next state DONE.
  - Otherwise: next state ADD.
  - No register update in CHECK.
- ADD:
  - `{carry,P_r} <= P_r + A_r`, computed W+1 bits wide.
  - `ovf_r <= ovf_r | carry`.
  - `B_r <= B_r - 1`.
  - Next state CHECK.
- DONE: `done=1`, next state IDLE. `product` and `ovf` keep their values.
- `product` and `ovf` keep their values after DONE until the next accepted `start`. On that start both clear in the same edge that loads the operands.
- `start` is ignored in CHECK, ADD and DONE. It is not queued.
- Operands are captured at acceptance. Changes on `a_in`/`b_in` afterwards have no effect.
- `B_r` never decrements below 0, because ADD is only entered with `eqz_b=0`. No wrap-around of the counter.
- Product result is (a_in × b_in) mod 2^W. `ovf=1` if and only if the true product is ≥ 2^W, since partial sums increase monotonically.
- Reset:
  - State returns to IDLE; `P_r`, `A_r`, `B_r` and `ovf_r` clear to 0; `busy=0`, `done=0`.
  - Reset in the middle of an operation aborts it with no `done` pulse.
  - If `rst` and `start` are both high on the same edge, `rst` wins.

## Timing
- Outputs are decoded from registered state and registers only. There is no combinational path from inputs to outputs.
- Let edge 0 be the edge that accepts `start`.
  - `busy` rises after edge 0.
  - `done` is high in the cycle after edge L, where L = 2·b_in + 2 if a_in ≠ 0, and L = 2 if a_in = 0 or b_in = 0.
  - `busy` is low in the `done` cycle.
- `product` is final no later than the `done` cycle.
- The earliest next `start` is accepted on the edge following the `done` cycle (back-to-back operations).
- Throughput: one operation per L+1 cycles.
- Reset values: `product=0`, `busy=0`, `done=0`, `ovf=0`.

## Test plan
- Basic product:
  - Stimulus: reset, then `start` with a=5, b=3.
  - Required: `busy` high from the next cycle; `done` pulses once, 8 edges after acceptance; `product=15`; `ovf=0`.
- Zero operands:
  - a=0, b=7 → `done` at L=2, `product=0`.
  - a=7, b=0 → `done` at L=2, `product=0`.
  - Both cases: no ADD cycles, `ovf=0`.
- Overflow (W=32):
  - Stimulus: a=0x8000_0000, b=3.
  - Required: `product=0x8000_0000`, `ovf=1`, `done` at L=8.
  - A following operation with a=2, b=2 gives `product=4` and `ovf=0` (sticky flag cleared at start).
- Start while busy:
  - Stimulus: a=4, b=4; change the inputs and pulse `start` again during ADD.
  - Required: result is 16 at L=10. The second pulse is ignored, and no extra `done` follows.
- Back-to-back:
  - Stimulus: assert `start` on the edge right after the `done` cycle, with a=3, b=2.
  - Required: accepted; `product` clears to 0 on that edge; final result 6 at L=6.
- Reset mid-operation:
  - Stimulus: a=9, b=9; assert `rst` for 1 cycle after 5 edges.
  - Required: `product=0`, `busy=0`, `done` never pulses.
  - A new `start` with a=2, b=3 then yields 6 at L=8.

Source files
------------

// File: rtl/mul_rpt_add.sv
// Sequential unsigned multiplier: adds A into the product B times, stepped by a
// four-state controller, with a one-cycle done pulse and a sticky carry-out flag.
module mul_rpt_add #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] product,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ADD   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] p_q;
  logic         ovf_q;
  logic         busy_q;
  logic         done_q;

  logic         eqz_a_s;
  logic         eqz_b_s;
  logic [W:0]   sum_s;

  assign eqz_a_s = (a_q == {W{1'b0}});
  assign eqz_b_s = (b_q == {W{1'b0}});
  assign sum_s   = {1'b0, p_q} + {1'b0, a_q};

  // Controller and datapath; done is registered off the DONE state so the
  // pulse lands in the cycle where the FSM is already back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      p_q     <= {W{1'b0}};
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            p_q     <= {W{1'b0}};
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (eqz_a_s || eqz_b_s) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          // ADD is only entered with a non-zero counter, so b_q never wraps.
          p_q     <= sum_s[W-1:0];
          ovf_q   <= ovf_q | sum_s[W];
          b_q     <= b_q - ONE;
          busy_q  <= 1'b1;
          state_q <= S_CHECK;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign product = p_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mul_rpt_add.sv
// Scoreboard bench for mul_rpt_add: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_rpt_add;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] product;
  logic         busy;
  logic         done;
  logic         ovf;

  typedef struct {
    logic [W-1:0] p;
    logic         o;
    int           acc;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  mul_rpt_add #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .product (product),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL spurious_done: actual=done required=no done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", product, e.p);
        check("ovf", {{(W-1){1'b0}}, ovf}, {{(W-1){1'b0}}, e.o});
        check("latency", cyc - e.acc, e.lat);
        check("busy_in_done", {{(W-1){1'b0}}, busy}, {W{1'b0}});
      end
    end
  end

  // Called at a negedge: drives one accepted start and queues its expectation.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] p, input logic o, input int lat);
    exp_t e;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.p   = p;
    e.o   = o;
    e.acc = cyc;
    e.lat = lat;
    exp_q.push_back(e);
    check("busy_after_accept", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, 1'b1});
    check("product_cleared", product, {W{1'b0}});
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL done_timeout: actual=no done required=done within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_product", product, {W{1'b0}});
    check("rst_busy", {{(W-1){1'b0}}, busy}, {W{1'b0}});
    check("rst_done", {{(W-1){1'b0}}, done}, {W{1'b0}});
    check("rst_ovf", {{(W-1){1'b0}}, ovf}, {W{1'b0}});
    @(negedge clk);

    run(32'd5, 32'd3, 32'd15, 1'b0, 8);                 wait_done(); idle(2);
    run(32'd0, 32'd7, 32'd0, 1'b0, 2);                  wait_done(); idle(2);
    run(32'd7, 32'd0, 32'd0, 1'b0, 2);                  wait_done(); idle(2);
    run(32'h8000_0000, 32'd3, 32'h8000_0000, 1'b1, 8);  wait_done(); idle(2);
    run(32'd2, 32'd2, 32'd4, 1'b0, 6);                  wait_done(); idle(2);

    // Second start during ADD with different operands must be ignored.
    run(32'd4, 32'd4, 32'd16, 1'b0, 10);
    @(negedge clk);
    @(negedge clk);
    a_in  = 32'd7;
    b_in  = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Back-to-back: start presented in the done cycle, accepted on the next edge.
    run(32'd3, 32'd2, 32'd6, 1'b0, 6);
    wait_done();
    idle(15);

    // Reset five edges into an operation aborts it without a done pulse.
    run(32'd9, 32'd9, 32'd81, 1'b0, 20);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("abort_product", product, {W{1'b0}});
    check("abort_busy", {{(W-1){1'b0}}, busy}, {W{1'b0}});
    check("abort_done", {{(W-1){1'b0}}, done}, {W{1'b0}});
    idle(30);

    run(32'd2, 32'd3, 32'd6, 1'b0, 8);
    wait_done();
    idle(20);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
